rf_power_avg_seq: RTL and testbench
===================================

// Module: rf_power_avg_seq
// PURPOSE
//  Parametrised multichannel RF-power averager. Steps an external analog mux through N_CH channels
//  and drives the serial-handshake ADC. Accumulates 2**LOG2_AVG samples per channel and stores the
//  average and peak per channel in a register bank. The bank is read by address, one cycle latency.
//  Sits between the SURF housekeeping ADC/mux pins and the CPCI register readout path.
// PARAMETERS
//  N_CH        8   number of mux channels; range 2..16; CH_W = clog2(N_CH)
//  ADC_W       12  ADC data width
//  LOG2_AVG    12  log2 of samples per channel; range 1..16
//  SAMPLE_DIV  16  CLK cycles between conversion starts; minimum 8
//  SETTLE_CLKS 64  CLK cycles of hold after each mux change, before sampling
//  BUSY_TMO    255 max CLK cycles allowed in WAITBUSY before the conversion is aborted
//  RAD_W       5   readout address width; must satisfy 2**RAD_W >= 2*N_CH+1
// PORTS
//  CLK        in  1       single system clock (33 MHz CPCI)
//  RST        in  1       synchronous, active-high reset
//  ch_mask    in  N_CH    1 = channel enabled; sampled at each channel advance
//  AD_nBusy   in  1       ADC busy, active low
//  AData      in  ADC_W   ADC parallel data
//  MUXSel     out CH_W    analog mux select
//  AD_nCONVST out 1       convert strobe, active low
//  AD_nCS     out 1       chip select; constant 0
//  AD_nRD     out 1       read strobe, active low
//  RAD        in  RAD_W   readout address
//  RFPWR      out 16      registered readout data
//  frame_done out 1       one-cycle pulse after the last enabled channel is stored
//  tmo_err    out 1       sticky flag; cleared only by RST
// BEHAVIOUR
//  Reset values: MUXSel=0, AD_nCONVST=1, AD_nRD=1, RFPWR=0, frame_done=0, tmo_err=0.
//   All bank entries, accumulator, peak, counters and frame_cnt are 0. Both FSMs return to SETTLE/S_IDLE.
//  Sequencer FSM states and transitions:
//   SETTLE: count SETTLE_CLKS, then go to ACQ.
//   ACQ: issue a sample request every SAMPLE_DIV clocks. Leave for STORE when valid samples = 2**LOG2_AVG.
//   STORE: one cycle. Write avg[ch] and pk[ch], clear acc, peak and sample count.
//   ADVANCE: one cycle. MUXSel becomes the next enabled channel, increasing with wrap.
//   ADVANCE then returns to SETTLE. Passing the highest enabled channel pulses frame_done and increments frame_cnt.
//  Channel mask rules:
//   ch_mask == 0: hold MUXSel, stay in SETTLE, no conversions.
//   A channel disabled mid-acquisition finishes its current average.
//  Sample FSM states and transitions:
//   S_IDLE: start only on a request with AD_nBusy=1; otherwise the request stays pending.
//   S_CONV: nCONVST low for 2 clocks.
//   S_WAIT: wait for AD_nBusy=1. After BUSY_TMO clocks: nCONVST=1, set tmo_err, discard the sample, return to S_IDLE.
//   S_READ: nCONVST=1, nRD low for 2 clocks.
//   S_CAP: nRD=1, acc += AData, peak = max(peak, AData), count+1, return to S_IDLE.
//  The sequencer never leaves ACQ while the sample FSM is not in S_IDLE.
//  Arithmetic: acc width = ADC_W+LOG2_AVG, cannot overflow.
//   avg = (acc + 2**(LOG2_AVG-1)) >> LOG2_AVG, rounded half-up, zero-extended to 16 bits.
//   pk is zero-extended to 16 bits.
//  Readout map: RAD<N_CH -> avg[RAD]; N_CH<=RAD<2N_CH -> pk[RAD-N_CH]; RAD==2N_CH -> frame_cnt (16b, wraps).
//   Any other RAD reads 0. RFPWR updates on the CLK edge after RAD.
//  Read/write collision: a STORE and a read of the same entry in one cycle return the old value.
//  RST mid-conversion: strobes return high on the next edge; the partial average is lost.
// STRUCTURE
//  Package rf_pow_pkg: seq_state_t {SETTLE,ACQ,STORE,ADVANCE}, smp_state_t {S_IDLE,S_CONV,S_WAIT,S_READ,S_CAP}.
//   Also clog2 function, readout map offset constants.
//  Sub-module ad_conv_hs: sample FSM plus timeout counter.
//   Handshake with the parent: req/ack, data, valid, tmo.
//  Parent holds the sequencer, accumulator/peak datapath, register bank and readout mux.
// TESTING
//  T1 ADC model (busy 3 clks, AData=ch*256+5), N_CH=8, LOG2_AVG=4, all enabled
//   -> avg[ch]=ch*256+5, pk equal; frame_done once per 8 stores.
//  T2 AData alternates 100/101, LOG2_AVG=1 -> avg=101 (half-up rounding); pk=101.
//  T3 ch_mask=8'b1010_0100 -> MUXSel sequence 2,5,7,2; no conversions with channels 0,1,3,4,6 selected.
//  T4 AD_nBusy stuck low for 300 clks -> tmo_err=1 after 255 clks in S_WAIT; nCONVST=1.
//   Then busy released -> sampling resumes; avg excludes the lost sample.
//  T5 Assert RST during S_READ -> next edge AD_nRD=1, bank=0, MUXSel=0.
//   Then RAD=16 after one frame -> RFPWR=1.
//  T6 Full sweep of RAD 0..31 with N_CH=8 -> entries 17..31 read 0.
//   Back-to-back RAD changes give 1-cycle latency.

Source files
------------

// File: rtl/rf_pow_pkg.sv
// Shared state types, sizing helper and readout map layout for the RF power averager.
package rf_pow_pkg;

   typedef enum logic [1:0] {SETTLE, ACQ, STORE, ADVANCE} seq_state_t;
   typedef enum logic [2:0] {S_IDLE, S_CONV, S_WAIT, S_READ, S_CAP} smp_state_t;

   localparam int CONV_CLKS = 2;
   localparam int READ_CLKS = 2;
   localparam int AVG_OFS   = 0;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Readout map: averages first, then peaks, then the frame counter.
   function automatic int pk_ofs(input int n_ch);
      return AVG_OFS + n_ch;
   endfunction

   function automatic int cnt_addr(input int n_ch);
      return AVG_OFS + 2 * n_ch;
   endfunction

endpackage

// File: rtl/ad_conv_hs.sv
// Serial-handshake ADC sample FSM: convert strobe, busy wait with timeout, read strobe, capture.
module ad_conv_hs import rf_pow_pkg::*; #(
   parameter int ADC_W    = 12,
   parameter int BUSY_TMO = 255
) (
   input  logic             CLK,
   input  logic             RST,
   // req is held while a sample is wanted; ack pulses in the cycle the request is taken;
   // valid pulses once with data; tmo pulses once when a conversion is abandoned.
   input  logic             req,
   output logic             ack,
   output logic [ADC_W-1:0] data,
   output logic             valid,
   output logic             tmo,
   input  logic             AD_nBusy,
   input  logic [ADC_W-1:0] AData,
   output logic             AD_nCONVST,
   output logic             AD_nRD,
   output smp_state_t       state
);

   localparam int TW = clog2(BUSY_TMO + 1);

   smp_state_t       state_q, state_d;
   logic [TW-1:0]    cnt_q, cnt_d;
   logic [ADC_W-1:0] data_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ack     = 1'b0;
      valid   = 1'b0;
      tmo     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req && AD_nBusy) begin
               state_d = S_CONV;
               cnt_d   = '0;
               ack     = 1'b1;
            end
         end
         S_CONV: begin
            if (cnt_q == TW'(CONV_CLKS - 1)) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT: begin
            if (AD_nBusy) begin
               state_d = S_READ;
               cnt_d   = '0;
            end else if (cnt_q == TW'(BUSY_TMO - 1)) begin
               state_d = S_IDLE;
               tmo     = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_READ: begin
            if (cnt_q == TW'(READ_CLKS - 1)) begin
               state_d = S_CAP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_CAP: begin
            valid   = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes are registered from the next state so the ADC pins never glitch.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         data_q     <= '0;
         AD_nCONVST <= 1'b1;
         AD_nRD     <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         AD_nCONVST <= (state_d != S_CONV);
         AD_nRD     <= (state_d != S_READ);
         if (state_q == S_READ && state_d == S_CAP) data_q <= AData;
      end
   end

   assign data  = data_q;
   assign state = state_q;

endmodule

// File: rtl/rf_power_avg_seq.sv
// Multichannel RF power averager: steps the mux, averages 2**LOG2_AVG samples per channel,
// keeps average and peak per channel and serves them through a registered readout port.
module rf_power_avg_seq import rf_pow_pkg::*; #(
   parameter int N_CH        = 8,
   parameter int ADC_W       = 12,
   parameter int LOG2_AVG    = 12,
   parameter int SAMPLE_DIV  = 16,
   parameter int SETTLE_CLKS = 64,
   parameter int BUSY_TMO    = 255,
   parameter int RAD_W       = 5
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [N_CH-1:0]          ch_mask,
   input  logic                     AD_nBusy,
   input  logic [ADC_W-1:0]         AData,
   output logic [clog2(N_CH)-1:0]   MUXSel,
   output logic                     AD_nCONVST,
   output logic                     AD_nCS,
   output logic                     AD_nRD,
   input  logic [RAD_W-1:0]         RAD,
   output logic [15:0]              RFPWR,
   output logic                     frame_done,
   output logic                     tmo_err,
   output seq_state_t               seq_state,
   output smp_state_t               smp_state
);

   localparam int CH_W  = clog2(N_CH);
   localparam int ACC_W = ADC_W + LOG2_AVG;
   localparam int CNT_W = LOG2_AVG + 1;
   localparam int SET_W = clog2(SETTLE_CLKS + 1);
   localparam int DIV_W = clog2(SAMPLE_DIV);
   localparam logic [CNT_W-1:0] N_AVG = CNT_W'(1) << LOG2_AVG;
   localparam logic [ACC_W-1:0] HALF  = ACC_W'(1) << (LOG2_AVG - 1);

   seq_state_t       seq_q, seq_d;
   logic [CH_W-1:0]  ch_q, nxt_ch, pk_idx;
   logic             nxt_wrap;
   logic [SET_W-1:0] set_cnt;
   logic [DIV_W-1:0] div_cnt;
   logic [CNT_W-1:0] smp_cnt;
   logic             req_pend, stored_q;
   logic [ACC_W-1:0] acc;
   logic [ADC_W-1:0] peak, avg_rnd, cdata;
   logic [ADC_W-1:0] avg_bank [N_CH];
   logic [ADC_W-1:0] pk_bank  [N_CH];
   logic [15:0]      frame_cnt;
   logic             req, ack, valid, tmo;

   ad_conv_hs #(.ADC_W(ADC_W), .BUSY_TMO(BUSY_TMO)) u_conv (
      .CLK        (CLK),
      .RST        (RST),
      .req        (req),
      .ack        (ack),
      .data       (cdata),
      .valid      (valid),
      .tmo        (tmo),
      .AD_nBusy   (AD_nBusy),
      .AData      (AData),
      .AD_nCONVST (AD_nCONVST),
      .AD_nRD     (AD_nRD),
      .state      (smp_state)
   );

   assign req     = req_pend && (smp_cnt < N_AVG) && (seq_q == ACQ);
   assign avg_rnd = ADC_W'((acc + HALF) >> LOG2_AVG);
   assign pk_idx  = CH_W'(RAD - RAD_W'(pk_ofs(N_CH)));

   // Nearest enabled channel above the current one, with wrap; staying put counts as a wrap.
   always_comb begin
      int j;
      j        = 0;
      nxt_ch   = ch_q;
      nxt_wrap = 1'b1;
      for (int i = N_CH - 1; i >= 1; i--) begin
         j = (int'(ch_q) + i) % N_CH;
         if (ch_mask[CH_W'(j)]) begin
            nxt_ch   = CH_W'(j);
            nxt_wrap = (int'(ch_q) + i) >= N_CH;
         end
      end
   end

   always_comb begin
      seq_d = seq_q;
      case (seq_q)
         SETTLE: begin
            if (ch_mask != '0) begin
               if (!ch_mask[ch_q])                            seq_d = ADVANCE;
               else if (set_cnt == SET_W'(SETTLE_CLKS - 1))   seq_d = ACQ;
            end
         end
         ACQ:     if (smp_cnt == N_AVG && smp_state == S_IDLE) seq_d = STORE;
         STORE:   seq_d = ADVANCE;
         ADVANCE: seq_d = SETTLE;
         default: seq_d = SETTLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         seq_q      <= SETTLE;
         ch_q       <= '0;
         set_cnt    <= '0;
         div_cnt    <= '0;
         smp_cnt    <= '0;
         req_pend   <= 1'b0;
         stored_q   <= 1'b0;
         acc        <= '0;
         peak       <= '0;
         frame_cnt  <= '0;
         frame_done <= 1'b0;
         tmo_err    <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            avg_bank[i] <= '0;
            pk_bank[i]  <= '0;
         end
      end else begin
         seq_q      <= seq_d;
         frame_done <= 1'b0;
         if (tmo) tmo_err <= 1'b1;
         case (seq_q)
            SETTLE: begin
               div_cnt <= '0;
               if (seq_d == SETTLE && ch_mask != '0) set_cnt <= set_cnt + 1'b1;
               else                                  set_cnt <= '0;
            end
            ACQ: begin
               div_cnt <= (div_cnt == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div_cnt + 1'b1;
               // A new tick re-arms the request even if the previous one is taken this cycle.
               if (div_cnt == '0) req_pend <= 1'b1;
               else if (ack)      req_pend <= 1'b0;
               if (valid) begin
                  acc     <= acc + ACC_W'(cdata);
                  smp_cnt <= smp_cnt + 1'b1;
                  if (cdata > peak) peak <= cdata;
               end
            end
            STORE: begin
               avg_bank[ch_q] <= avg_rnd;
               pk_bank[ch_q]  <= peak;
               acc            <= '0;
               peak           <= '0;
               smp_cnt        <= '0;
               req_pend       <= 1'b0;
               stored_q       <= 1'b1;
            end
            ADVANCE: begin
               ch_q <= nxt_ch;
               if (nxt_wrap) begin
                  stored_q <= 1'b0;
                  if (stored_q) begin
                     frame_done <= 1'b1;
                     frame_cnt  <= frame_cnt + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Reads see the bank before any same-edge STORE, so a collision returns the old value.
   always_ff @(posedge CLK) begin
      if (RST)                                     RFPWR <= '0;
      else if (RAD < RAD_W'(N_CH))                 RFPWR <= 16'(avg_bank[RAD[CH_W-1:0]]);
      else if (RAD < RAD_W'(cnt_addr(N_CH)))       RFPWR <= 16'(pk_bank[pk_idx]);
      else if (RAD == RAD_W'(cnt_addr(N_CH)))      RFPWR <= frame_cnt;
      else                                         RFPWR <= '0;
   end

   assign MUXSel    = ch_q;
   assign AD_nCS    = 1'b0;
   assign seq_state = seq_q;

endmodule

// File: tb/tb_rf_power_avg_seq.sv
// Bench for rf_power_avg_seq: ADC/mux model, table-driven readout with an expected queue,
// and hand-written sequences for mask skipping, busy timeout and mid-read reset.
module tb_rf_power_avg_seq;
   import rf_pow_pkg::*;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [7:0]  ch_mask = 8'hFF;
   logic        AD_nBusy = 1'b1;
   logic [11:0] AData = 12'd0;
   logic [2:0]  MUXSel;
   logic        AD_nCONVST, AD_nCS, AD_nRD;
   logic [4:0]  RAD = 5'd0;
   logic [15:0] RFPWR;
   logic        frame_done, tmo_err;
   seq_state_t  seq_state;
   smp_state_t  smp_state;

   rf_power_avg_seq #(
      .N_CH(8), .ADC_W(12), .LOG2_AVG(4), .SAMPLE_DIV(16),
      .SETTLE_CLKS(64), .BUSY_TMO(255), .RAD_W(5)
   ) dut (
      .CLK(CLK), .RST(RST), .ch_mask(ch_mask), .AD_nBusy(AD_nBusy), .AData(AData),
      .MUXSel(MUXSel), .AD_nCONVST(AD_nCONVST), .AD_nCS(AD_nCS), .AD_nRD(AD_nRD),
      .RAD(RAD), .RFPWR(RFPWR), .frame_done(frame_done), .tmo_err(tmo_err),
      .seq_state(seq_state), .smp_state(smp_state)
   );

   // ---------------- clock ----------------
   always #15 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- ADC model: busy 3 clks per conversion ----------------
   int   busy_cnt = 0;
   logic conv_seen = 1'b0;
   logic alt = 1'b0;
   logic stuck = 1'b0;
   int   mode = 0;

   always @(negedge CLK) begin
      if (busy_cnt > 0) busy_cnt--;
      if (!AD_nCONVST && !conv_seen) begin
         busy_cnt = 3;
         alt = ~alt;
      end
      conv_seen = !AD_nCONVST;
      AD_nBusy  = (busy_cnt == 0) && !stuck;
      AData     = (mode == 0) ? {1'b0, MUXSel, 8'd5} : (alt ? 12'd101 : 12'd100);
   end

   // ---------------- monitors ----------------
   int         fd_cnt = 0, store_cnt = 0, bad_conv = 0, cap_cnt = 0;
   logic [2:0] mux_log[$];
   logic [2:0] mux_prev = 3'd0;

   always @(negedge CLK) begin
      if (frame_done) fd_cnt++;
      if (seq_state == STORE) store_cnt++;
      if (seq_state == ADVANCE) cap_cnt = 0;
      else if (smp_state == S_CAP) cap_cnt++;
      if (!AD_nCONVST && !ch_mask[MUXSel]) bad_conv++;
      if (MUXSel != mux_prev) mux_log.push_back(MUXSel);
      mux_prev = MUXSel;
   end

   // ---------------- scoreboard ----------------
   int n_cmp = 0, n_err = 0;

   typedef struct {
      logic [4:0]  rad;
      logic [15:0] exp;
   } rd_vec_t;

   rd_vec_t     vecs[$];
   logic [15:0] exp_q[$];
   logic [4:0]  rad_q[$];

   task automatic tick();
      @(negedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [4:0] r, input logic [15:0] e);
      rd_vec_t v;
      v.rad = r;
      v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic pop_check(input string name);
      logic [4:0]  r;
      logic [15:0] e;
      r = rad_q.pop_front();
      e = exp_q.pop_front();
      check($sformatf("%s rad=%0d", name, r), 32'(RFPWR), 32'(e));
   endtask

   // One RAD per cycle; each result is compared one cycle after its address.
   task automatic run_reads(input string name);
      for (int i = 0; i < vecs.size(); i++) begin
         tick();
         if (exp_q.size() > 0) pop_check(name);
         RAD = vecs[i].rad;
         rad_q.push_back(vecs[i].rad);
         exp_q.push_back(vecs[i].exp);
      end
      tick();
      if (exp_q.size() > 0) pop_check(name);
      vecs.delete();
   endtask

   task automatic wait_fd(input int target, input string name);
      int t;
      t = 0;
      while (fd_cnt < target && t < 6000) begin
         tick();
         t++;
      end
      check({name, " frame_done seen"}, 32'(fd_cnt >= target), 32'd1);
   endtask

   task automatic wait_smp(input smp_state_t s, input string name);
      int t;
      t = 0;
      while (smp_state != s && t < 2000) begin
         tick();
         t++;
      end
      check({name, " reached"}, 32'(smp_state == s), 32'd1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int         e, n, t, base, mux_base, st_base, bad_base;
      logic [2:0] tch;
      logic [2:0] exp_mux[4];

      exp_mux[0] = 3'd2; exp_mux[1] = 3'd5; exp_mux[2] = 3'd7; exp_mux[3] = 3'd2;

      repeat (3) tick();
      check("rst MUXSel",     32'(MUXSel),     32'd0);
      check("rst AD_nCONVST", 32'(AD_nCONVST), 32'd1);
      check("rst AD_nRD",     32'(AD_nRD),     32'd1);
      check("rst AD_nCS",     32'(AD_nCS),     32'd0);
      check("rst RFPWR",      32'(RFPWR),      32'd0);
      check("rst frame_done", 32'(frame_done), 32'd0);
      check("rst tmo_err",    32'(tmo_err),    32'd0);
      check("rst seq_state",  32'(seq_state),  32'(SETTLE));
      check("rst smp_state",  32'(smp_state),  32'(S_IDLE));

      // T1 + T6: one full frame of constant data, then a back-to-back sweep of every address
      st_base = store_cnt;
      RST = 1'b0;
      wait_fd(1, "t1");
      check("t1 stores per frame", 32'(store_cnt - st_base), 32'd8);
      mode = 1;
      for (int r = 0; r < 32; r++) begin
         if (r < 8)        e = r * 256 + 5;
         else if (r < 16)  e = (r - 8) * 256 + 5;
         else if (r == 16) e = 1;
         else              e = 0;
         add_vec(5'(r), 16'(e));
      end
      run_reads("t1 sweep");

      // T2: 100/101 alternating averages to 101 with half-up rounding
      wait_fd(2, "t2");
      mode = 0;
      ch_mask = 8'b1010_0100;
      mux_base = mux_log.size();
      bad_base = bad_conv;
      add_vec(5'd0, 16'd101);
      add_vec(5'd3, 16'd101);
      add_vec(5'd7, 16'd101);
      add_vec(5'd13, 16'd101);
      add_vec(5'd16, 16'd2);
      run_reads("t2 round");

      // T3: only channels 2,5,7 are visited and converted
      t = 0;
      while (mux_log.size() < mux_base + 4 && t < 3000) begin
         tick();
         t++;
      end
      check("t3 mux steps seen", 32'(mux_log.size() >= mux_base + 4), 32'd1);
      for (int i = 0; i < 4; i++)
         if (mux_log.size() > mux_base + i)
            check($sformatf("t3 mux step %0d", i), 32'(mux_log[mux_base + i]), 32'(exp_mux[i]));
      check("t3 disabled-channel conversions", 32'(bad_conv - bad_base), 32'd0);
      check("t3 frame count", 32'(fd_cnt), 32'd3);
      add_vec(5'd0, 16'd101);
      add_vec(5'd2, 16'd517);
      add_vec(5'd11, 16'd101);
      add_vec(5'd13, 16'd1285);
      add_vec(5'd15, 16'd1797);
      add_vec(5'd16, 16'd3);
      run_reads("t3 mask");

      // T4: busy stuck low during a conversion
      wait_smp(S_CONV, "t4 conv");
      tch = MUXSel;
      stuck = 1'b1;
      wait_smp(S_WAIT, "t4 wait");
      check("t4 tmo_err before timeout", 32'(tmo_err), 32'd0);
      n = 0;
      while (smp_state == S_WAIT && n < 400) begin
         n++;
         tick();
      end
      check("t4 clocks in S_WAIT", 32'(n), 32'd255);
      check("t4 tmo_err set", 32'(tmo_err), 32'd1);
      check("t4 AD_nCONVST", 32'(AD_nCONVST), 32'd1);
      check("t4 back to idle", 32'(smp_state), 32'(S_IDLE));
      repeat (40) tick();
      stuck = 1'b0;
      t = 0;
      while (seq_state != STORE && t < 2000) begin
         tick();
         t++;
      end
      check("t4 store reached", 32'(seq_state == STORE), 32'd1);
      check("t4 valid samples", 32'(cap_cnt), 32'd16);
      check("t4 tmo_err sticky", 32'(tmo_err), 32'd1);
      add_vec(5'(tch), 16'(tch * 256 + 5));
      add_vec(5'(tch + 8), 16'(tch * 256 + 5));
      run_reads("t4 avg");

      // T5: reset in the middle of a read strobe
      wait_smp(S_READ, "t5 read");
      RST = 1'b1;
      tick();
      check("t5 AD_nRD", 32'(AD_nRD), 32'd1);
      check("t5 AD_nCONVST", 32'(AD_nCONVST), 32'd1);
      check("t5 MUXSel", 32'(MUXSel), 32'd0);
      check("t5 tmo_err", 32'(tmo_err), 32'd0);
      check("t5 smp_state", 32'(smp_state), 32'(S_IDLE));
      ch_mask = 8'hFF;
      RST = 1'b0;
      add_vec(5'd0, 16'd0);
      add_vec(5'd2, 16'd0);
      add_vec(5'd13, 16'd0);
      add_vec(5'd16, 16'd0);
      run_reads("t5 cleared");
      base = fd_cnt;
      wait_fd(base + 1, "t5");
      add_vec(5'd16, 16'd1);
      add_vec(5'd3, 16'd773);
      run_reads("t5 after frame");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
